irq_enc_8_to_3: RTL and testbench
=================================

Name: irq_enc_8_to_3

Overview:
- Registered 8-to-3 request encoder for the 6-bit CPU. It is the inverse of the 3-to-8 select decoder.
- Captures up to 8 request lines into a pending register and arbitrates among unmasked pending bits. It presents the winning 3-bit index to the control unit with a VALID/ACK handshake.
- Sits between peripheral request lines and the CPU interrupt/dispatch logic.

Parameters:
- EDGE_MODE, 1: 1 sets a pending bit on a REQ rising edge; 0 sets it whenever REQ is high (level).
- HI_FIRST, 1: 1 makes bit 7 the highest priority; 0 makes bit 0 the highest priority.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- REQ  in  8  request lines, synchronous to CLK.
- MASK  in  8  1 = request bit excluded from arbitration; the bit still pends.
- ACK  in  1  consumer accepts the presented CODE.
- CLR_ALL  in  1  synchronous flush of all pending requests.
- VALID  out  1  CODE holds a valid, unacknowledged request index.
- CODE  out  3  index of the presented request.
- PEND  out  8  pending register contents, for debug/status.

Behaviour:
- Reset (RST_N=0, async): PEND=8'h00, req_d=8'h00, VALID=0, CODE=3'b000, state=IDLE.
- Capture:
  - EDGE_MODE=1: set_vec = REQ & ~req_d, where req_d is REQ registered each cycle.
  - EDGE_MODE=0: set_vec = REQ.
  - PEND <= (PEND & ~clr_vec) | set_vec. If set and clear hit the same bit in one cycle, set wins.
- clr_vec is one-hot at CODE on an accepted ACK, otherwise 0.
- Eligible vector: elig = PEND & ~MASK.
- FSM states and transitions:
  - IDLE: if elig != 0, latch CODE = priority index of elig, VALID<=1, go to PRESENT. Otherwise stay in IDLE.
  - PRESENT: CODE and VALID are held stable regardless of REQ/MASK changes. If ACK=1: clear PEND[CODE], VALID<=0, go to GAP.
  - GAP: one idle cycle, VALID=0, then go to IDLE. This guarantees VALID deasserts for at least one cycle between grants.
- Latency (EDGE_MODE=1):
  - REQ rising before edge N sets PEND at edge N.
  - VALID is asserted after edge N+1.
  - Back-to-back grants are a minimum of 3 cycles apart: ACK edge, then GAP, then IDLE->PRESENT.
- Accepted ACK: sampled at the rising edge while state=PRESENT.
- ACK in IDLE or GAP is ignored and clears nothing.
- MASK asserted on the presented bit while in PRESENT: no effect. The grant stays until ACK.
- CLR_ALL=1 (synchronous, highest priority):
  - PEND<=0, VALID<=0, state<=IDLE; same-cycle set_vec and ACK are discarded.
  - req_d still updates, so a held-high REQ does not re-trigger in edge mode.
- Level mode: an acked bit whose REQ is still high is re-pended at the next edge.
- All PEND bits masked: stay in IDLE, VALID=0, PEND retained.
- RST_N asserted mid-handshake: immediate return to reset values. ACK arriving after release is ignored.

Optional Feature:
- Macro: ROTATE_PRIO_EN.
- Defined:
  - Round-robin arbitration. A 3-bit pointer LAST (reset 3'b111) records the last granted index on each accepted ACK.
  - The next search starts at LAST+1 mod 8 in ascending order and wraps. HI_FIRST is ignored.
  - LAST is cleared to 3'b111 by CLR_ALL.
- Not defined: fixed priority per HI_FIRST; no LAST register is present.

Test Plan:
- Reset/idle: RST_N=0 then 1, REQ=0 -> VALID=0, CODE=000, PEND=00 for 10 cycles.
- Single request: REQ=8'h02 pulse, MASK=0 -> PEND=02 after edge 1, VALID=1 with CODE=001 after edge 2. Hold ACK=0 for 5 cycles -> CODE stable. ACK=1 for one cycle -> PEND=00, VALID=0.
- Fixed priority: REQ=8'h81 in one cycle, HI_FIRST=1 -> first CODE=111. ACK -> one GAP cycle with VALID=0, then CODE=000. ACK -> PEND=00.
- Masking: PEND=8'h24 with MASK=8'h20 -> CODE=010. Ack that grant, then set MASK=0 -> CODE=101.
- Collision/flush:
  - New REQ[3] edge on the same cycle that ACK clears bit 3 -> PEND[3] stays 1 and is re-granted.
  - CLR_ALL while VALID=1 -> VALID=0 and PEND=00 next cycle; a later ACK is ignored.
- ROTATE_PRIO_EN: REQ=8'hFF held pending -> successive CODEs are 0,1,...,7. The first CODE after CLR_ALL is 000.

Source files
------------

// File: rtl/irq_enc_8_to_3.sv
// Registered 8-to-3 request encoder: pending capture, masked arbitration, VALID/ACK grant.
// Latency: request edge pends at edge N, VALID after edge N+1; grants are >= 3 cycles apart.
// Backpressure: CODE/VALID hold until ACK; optional round-robin under `ifdef ROTATE_PRIO_EN.
module irq_enc_8_to_3 #(
    parameter int EDGE_MODE = 1,
    parameter int HI_FIRST  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic [7:0] mask,
    input  logic       ack,
    input  logic       clr_all,
    output logic       valid,
    output logic [2:0] code,
    output logic [7:0] pend
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] PRESENT = 2'd1;
    localparam logic [1:0] GAP     = 2'd2;

    logic [1:0] state;
    logic [7:0] req_d;
    logic [7:0] set_vec;
    logic [7:0] clr_vec;
    logic [7:0] elig;
    logic [7:0] pend_nxt;
    logic [2:0] win;
    logic       accept;

    assign accept   = (state == PRESENT) && ack;
    assign set_vec  = (EDGE_MODE != 0) ? (req & ~req_d) : req;
    assign clr_vec  = accept ? (8'd1 << code) : 8'd0;
    // Set is applied after clear so a same-cycle new request survives the ACK.
    assign pend_nxt = (pend & ~clr_vec) | set_vec;
    assign elig     = pend & ~mask;

`ifdef ROTATE_PRIO_EN
    logic [2:0] last;
    logic [2:0] idx;
    logic       found;

    always_comb begin
        win   = 3'd0;
        idx   = 3'd0;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx = last + 3'd1 + 3'(i);
            if (!found && elig[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= 3'b111;
        end else if (clr_all) begin
            last <= 3'b111;
        end else if (accept) begin
            last <= code;
        end
    end
`else
    always_comb begin
        win = 3'd0;
        if (HI_FIRST != 0) begin
            for (int i = 0; i < 8; i++) begin
                if (elig[i]) win = 3'(i);
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (elig[i]) win = 3'(i);
            end
        end
    end
`endif

    // Edge history keeps tracking through a flush so a held request does not re-fire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_d <= 8'h00;
        end else begin
            req_d <= req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend  <= 8'h00;
            valid <= 1'b0;
            code  <= 3'b000;
            state <= IDLE;
        end else if (clr_all) begin
            pend  <= 8'h00;
            valid <= 1'b0;
            state <= IDLE;
        end else begin
            pend <= pend_nxt;
            case (state)
                IDLE: begin
                    if (|elig) begin
                        code  <= win;
                        valid <= 1'b1;
                        state <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (ack) begin
                        valid <= 1'b0;
                        state <= GAP;
                    end
                end
                GAP:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_enc_8_to_3.sv
// Bench for irq_enc_8_to_3 (EDGE_MODE=1, HI_FIRST=1); grant order is scoreboarded.
module tb_irq_enc_8_to_3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] mask;
    logic       ack;
    logic       clr_all;
    logic       valid;
    logic [2:0] code;
    logic [7:0] pend;

    int checks = 0;
    int errors = 0;
    logic [2:0] exp_q[$];
    logic [2:0] m_last = 3'b111;

    typedef struct {
        logic [7:0] req;
        logic [2:0] first_code;
    } vec_t;
    vec_t vecs[6];

    irq_enc_8_to_3 #(.EDGE_MODE(1), .HI_FIRST(1)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .ack(ack),
        .clr_all(clr_all), .valid(valid), .code(code), .pend(pend)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [2:0] c);
        exp_q.push_back(c);
        m_last = c;
    endtask

    // Expected grant order when pattern p is all pending and unmasked at once.
    task automatic push_order(input logic [7:0] p);
        logic [7:0] rem;
        logic [2:0] idx;
        rem = p;
`ifdef ROTATE_PRIO_EN
        while (rem != 8'h00) begin
            for (int i = 0; i < 8; i++) begin
                idx = m_last + 3'd1 + 3'(i);
                if (rem[idx]) begin
                    push_exp(idx);
                    rem[idx] = 1'b0;
                    break;
                end
            end
        end
`else
        for (int i = 7; i >= 0; i--) begin
            if (rem[i]) push_exp(3'(i));
        end
`endif
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!valid && n < 20) begin
            tick();
            n++;
        end
        chk(name, {31'd0, valid}, 32'd1);
    endtask

    task automatic grant_one(input string name);
        wait_valid(name);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk({name, "_gap"}, {31'd0, valid}, 32'd0);
    endtask

    task automatic pulse(input logic [7:0] p);
        req = p;
        tick();
        req = 8'h00;
    endtask

    // Every accepted handshake must match the next expected code.
    always @(negedge clk) begin
        if (valid && ack) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_grant: got code %0d expected none", code);
            end else begin
                chk("grant_code", {29'd0, code}, {29'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h01, 3'd0};
        vecs[1] = '{8'h80, 3'd7};
        vecs[2] = '{8'hff, 3'd7};
        vecs[3] = '{8'h55, 3'd6};
        vecs[4] = '{8'h0e, 3'd3};
        vecs[5] = '{8'h18, 3'd4};

        rst_n = 1'b0; req = 8'h00; mask = 8'h00; ack = 1'b0; clr_all = 1'b0;
        #12;
        chk("reset_state", {20'd0, valid, code, pend}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_state", {20'd0, valid, code, pend}, 32'd0);
        end

        // Single request latency and hold.
        pulse(8'h02);
        chk("single_pend", {23'd0, valid, pend}, {23'd0, 1'b0, 8'h02});
        tick();
        chk("single_valid", {28'd0, valid, code}, {28'd0, 1'b1, 3'd1});
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("single_hold", {28'd0, valid, code}, {28'd0, 1'b1, 3'd1});
        end
        push_exp(3'd1);
        grant_one("single_ack");
        chk("single_clear", {23'd0, valid, pend}, 32'd0);

        // Two requests: back-to-back spacing.
        pulse(8'h81);
        push_order(8'h81);
        grant_one("pair_first");
        tick();
        chk("pair_idle", {31'd0, valid}, 32'd0);
        tick();
        chk("pair_second", {28'd0, valid, code}, {28'd0, 1'b1, 3'd0});
        grant_one("pair_second_ack");
        chk("pair_clear", {24'd0, pend}, 32'd0);

        // Masked bit still pends but is skipped.
        mask = 8'h20;
        pulse(8'h24);
        push_exp(3'd2);
        grant_one("mask_first");
        tick();
        chk("mask_retained", {23'd0, valid, pend}, {23'd0, 1'b0, 8'h20});
        mask = 8'h00;
        push_exp(3'd5);
        grant_one("mask_second");
        chk("mask_clear", {24'd0, pend}, 32'd0);

        for (int v = 0; v < 6; v++) begin
            pulse(vecs[v].req);
            chk("vec_pend", {24'd0, pend}, {24'd0, vecs[v].req});
            push_order(vecs[v].req);
`ifndef ROTATE_PRIO_EN
            wait_valid("vec_wait");
            chk("vec_first", {29'd0, code}, {29'd0, vecs[v].first_code});
`endif
            for (int k = 0; k < $countones(vecs[v].req); k++) grant_one("vec_grant");
            chk("vec_drain", {24'd0, pend}, 32'd0);
        end

        // New edge on the bit being acked: set wins, bit is re-granted.
        pulse(8'h08);
        push_exp(3'd3);
        push_exp(3'd3);
        wait_valid("coll_wait");
        req = 8'h08;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        req = 8'h00;
        chk("coll_pend", {23'd0, valid, pend}, {23'd0, 1'b0, 8'h08});
        grant_one("coll_regrant");
        chk("coll_clear", {24'd0, pend}, 32'd0);

        // Flush during a grant; later ACK is ignored.
        pulse(8'h30);
        wait_valid("flush_wait");
        clr_all = 1'b1;
        tick();
        clr_all = 1'b0;
        m_last = 3'b111;
        chk("flush_state", {23'd0, valid, pend}, 32'd0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        chk("flush_ack_ignored", {23'd0, valid, pend}, 32'd0);
        req = 8'h40;
        clr_all = 1'b1;
        tick();
        clr_all = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("flush_held_req", {23'd0, valid, pend}, 32'd0);
        end
        req = 8'h00;
        tick();

        // First grants after a flush; all eight bits pending.
        pulse(8'hff);
        push_order(8'hff);
        for (int k = 0; k < 8; k++) grant_one("after_flush");
        chk("after_flush_clear", {24'd0, pend}, 32'd0);

        // Reset in the middle of a handshake.
        pulse(8'h01);
        wait_valid("rst_wait");
        #2 rst_n = 1'b0;
        m_last = 3'b111;
        #1;
        chk("rst_async", {20'd0, valid, code, pend}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        chk("rst_ack_ignored", {23'd0, valid, pend}, 32'd0);

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
